// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - keycodes, direction and motion-state types for the sprite mover
package sprite_pkg;

  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_SPACE = 8'h2C;

  typedef enum logic [2:0] {
    DIR_NONE,
    DIR_UP,
    DIR_DOWN,
    DIR_LEFT,
    DIR_RIGHT
  } dir_t;

  typedef enum logic [1:0] {
    IDLE,
    MOVING,
    PAUSED
  } motion_state_t;

  // Map a keycode to the direction it steers; anything else is DIR_NONE.
  function automatic dir_t key_to_dir(input logic [7:0] key);
    case (key)
      KEY_W:   key_to_dir = DIR_UP;
      KEY_S:   key_to_dir = DIR_DOWN;
      KEY_A:   key_to_dir = DIR_LEFT;
      KEY_D:   key_to_dir = DIR_RIGHT;
      default: key_to_dir = DIR_NONE;
    endcase
  endfunction

  // Opposite direction on the same axis, used when an edge reflects the sprite.
  function automatic dir_t reverse_dir(input dir_t d);
    case (d)
      DIR_UP:    reverse_dir = DIR_DOWN;
      DIR_DOWN:  reverse_dir = DIR_UP;
      DIR_LEFT:  reverse_dir = DIR_RIGHT;
      DIR_RIGHT: reverse_dir = DIR_LEFT;
      default:   reverse_dir = DIR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/sprite_motion_axis_step.sv
// rtl/sprite_motion_axis_step.sv - one-axis position advance with clamp and reflect
module axis_step #(
  parameter int COORD_W = 10,
  parameter int MIN     = 0,
  parameter int MAX     = 639,
  parameter int SIZE    = 4
) (
  input  logic        [COORD_W-1:0] pos,
  input  logic signed [COORD_W-1:0] vel,
  output logic        [COORD_W-1:0] next_pos,
  output logic                      reflect
);

  // One extra bit so a step past zero or past the top stays comparable as signed.
  localparam logic signed [COORD_W:0] HI = (COORD_W+1)'(MAX - SIZE);
  localparam logic signed [COORD_W:0] LO = (COORD_W+1)'(MIN + SIZE);

  logic signed [COORD_W:0] cand;

  // Candidate position, then clamp to the inner edge and flag a reflection.
  always_comb begin
    cand     = signed'({1'b0, pos}) + signed'({vel[COORD_W-1], vel});
    next_pos = cand[COORD_W-1:0];
    reflect  = 1'b0;
    if (cand > HI) begin
      next_pos = HI[COORD_W-1:0];
      reflect  = 1'b1;
    end else if (cand < LO) begin
      next_pos = LO[COORD_W-1:0];
      reflect  = 1'b1;
    end
  end

endmodule

// File: rtl/sprite_motion.sv
// rtl/sprite_motion.sv - keyboard-steered sprite mover with speed ramp, pause and edge reflect
module sprite_motion
  import sprite_pkg::*;
#(
  parameter int COORD_W     = 10,
  parameter int X_CENTER    = 320,
  parameter int Y_CENTER    = 240,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 639,
  parameter int Y_MIN       = 0,
  parameter int Y_MAX       = 479,
  parameter int SIZE        = 4,
  parameter int STEP_MIN    = 1,
  parameter int STEP_MAX    = 4,
  parameter int RAMP_FRAMES = 8
) (
  input  logic               Reset,
  input  logic               frame_clk,
  input  logic [7:0]         keycode,
  output logic [COORD_W-1:0] SpriteX,
  output logic [COORD_W-1:0] SpriteY,
  output logic [COORD_W-1:0] SpriteS,
  output logic [COORD_W-1:0] VelX,
  output logic [COORD_W-1:0] VelY,
  output logic               Moving,
  output logic               Paused,
  output logic               Bounce
);

  localparam int CNT_W = (RAMP_FRAMES > 1) ? $clog2(RAMP_FRAMES) : 1;

  motion_state_t state_q, next_state, resume_q, resume_d;
  dir_t          dir_q, dir_k, dir_d, key_dir;
  logic [COORD_W-1:0] speed_q, speed_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         key_q;
  logic [COORD_W-1:0] pos_x_q, pos_y_q, pos_x_d, pos_y_d;
  logic signed [COORD_W-1:0] vel_x, vel_y, vel_x_q, vel_y_q;
  logic key_edge, space_edge, move, reflect_x, reflect_y, bounce_q;

  assign key_edge   = (keycode != key_q);
  assign space_edge = (keycode == KEY_SPACE) && (key_q != KEY_SPACE);
  assign key_dir    = key_to_dir(keycode);

  // State register plus all motion state; reset is asynchronous so a mid-frame reset lands at once.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      resume_q <= IDLE;
      dir_q    <= DIR_NONE;
      speed_q  <= COORD_W'(STEP_MIN);
      cnt_q    <= '0;
      key_q    <= 8'h00;
      pos_x_q  <= COORD_W'(X_CENTER);
      pos_y_q  <= COORD_W'(Y_CENTER);
      vel_x_q  <= '0;
      vel_y_q  <= '0;
      bounce_q <= 1'b0;
    end else begin
      state_q  <= next_state;
      resume_q <= resume_d;
      dir_q    <= dir_d;
      speed_q  <= speed_d;
      cnt_q    <= cnt_d;
      key_q    <= keycode;
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
      vel_x_q  <= vel_x;
      vel_y_q  <= vel_y;
      bounce_q <= reflect_x | reflect_y;
    end
  end

  // Key processing and next state: pause toggle first, then direction edge, then speed ramp.
  always_comb begin
    next_state = state_q;
    resume_d   = resume_q;
    dir_k      = dir_q;
    speed_d    = speed_q;
    cnt_d      = cnt_q;
    move       = 1'b0;
    case (state_q)
      IDLE, MOVING: begin
        if (space_edge) begin
          next_state = PAUSED;
          resume_d   = state_q;
        end else begin
          if (key_edge && key_dir != DIR_NONE) begin
            dir_k      = key_dir;
            speed_d    = COORD_W'(STEP_MIN);
            cnt_d      = '0;
            next_state = MOVING;
          end else if (state_q == MOVING) begin
            if (!key_edge && key_dir == dir_q) begin
              if (cnt_q == CNT_W'(RAMP_FRAMES - 1)) begin
                cnt_d = '0;
                if (speed_q < COORD_W'(STEP_MAX)) speed_d = speed_q + 1'b1;
              end else begin
                cnt_d = cnt_q + 1'b1;
              end
            end else begin
              cnt_d = '0;
            end
          end
          move = (next_state == MOVING);
        end
      end
      PAUSED: begin
        if (space_edge) begin
          next_state = resume_q;
          move       = (resume_q == MOVING);
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Velocity for this frame from the post-key direction and speed; zero when not moving.
  always_comb begin
    vel_x = '0;
    vel_y = '0;
    if (move) begin
      case (dir_k)
        DIR_RIGHT: vel_x = speed_d;
        DIR_LEFT:  vel_x = -speed_d;
        DIR_DOWN:  vel_y = speed_d;
        DIR_UP:    vel_y = -speed_d;
        default:   ;
      endcase
    end
  end

  axis_step #(.COORD_W(COORD_W), .MIN(X_MIN), .MAX(X_MAX), .SIZE(SIZE)) u_axis_x (
    .pos      (pos_x_q),
    .vel      (vel_x),
    .next_pos (pos_x_d),
    .reflect  (reflect_x)
  );

  axis_step #(.COORD_W(COORD_W), .MIN(Y_MIN), .MAX(Y_MAX), .SIZE(SIZE)) u_axis_y (
    .pos      (pos_y_q),
    .vel      (vel_y),
    .next_pos (pos_y_d),
    .reflect  (reflect_y)
  );

  // A reflection flips the sign of travel after the key has already chosen the direction.
  always_comb begin
    dir_d = dir_k;
    if (reflect_x || reflect_y) dir_d = reverse_dir(dir_k);
  end

  assign SpriteX = pos_x_q;
  assign SpriteY = pos_y_q;
  assign SpriteS = COORD_W'(SIZE);
  assign VelX    = vel_x_q;
  assign VelY    = vel_y_q;
  assign Moving  = (state_q == MOVING);
  assign Paused  = (state_q == PAUSED);
  assign Bounce  = bounce_q;

endmodule

// File: tb/tb_sprite_motion.sv
// tb/tb_sprite_motion.sv - randomized self-checking bench for sprite_motion
module tb_sprite_motion;

  localparam int XC = 320, YC = 240, XLO = 4, XHI = 635, YLO = 4, YHI = 475;
  localparam int SMIN = 1, SMAX = 4, RAMP = 8;

  logic       Reset;
  logic       frame_clk;
  logic [7:0] keycode;
  logic [9:0] SpriteX, SpriteY, SpriteS, VelX, VelY;
  logic       Moving, Paused, Bounce;

  int checks = 0;
  int errors = 0;

  // reference state: plain integers, direction 0 none 1 up 2 down 3 left 4 right,
  // mode 0 idle 1 moving 2 paused
  int px, py, mdir, spd, cnt, keyq, mode, resume_mode, evx, evy, ebounce;

  sprite_motion dut (
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .keycode   (keycode),
    .SpriteX   (SpriteX),
    .SpriteY   (SpriteY),
    .SpriteS   (SpriteS),
    .VelX      (VelX),
    .VelY      (VelY),
    .Moving    (Moving),
    .Paused    (Paused),
    .Bounce    (Bounce)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int dir_of(input int k);
    case (k)
      8'h1A:   return 1;
      8'h16:   return 2;
      8'h04:   return 3;
      8'h07:   return 4;
      default: return 0;
    endcase
  endfunction

  function automatic int flip(input int d);
    case (d)
      1: return 2;
      2: return 1;
      3: return 4;
      4: return 3;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    px = XC; py = YC; mdir = 0; spd = SMIN; cnt = 0; keyq = 0;
    mode = 0; resume_mode = 0; evx = 0; evy = 0; ebounce = 0;
  endtask

  task automatic model_step(input int k);
    bit chg, sp, mv;
    int kd, cx, cy;
    chg = (k != keyq);
    sp  = (k == 8'h2C) && (keyq != 8'h2C);
    kd  = dir_of(k);
    mv  = 0;
    if (mode != 2) begin
      if (sp) begin
        resume_mode = mode;
        mode = 2;
      end else begin
        if (chg && kd != 0) begin
          mdir = kd; spd = SMIN; cnt = 0; mode = 1;
        end else if (mode == 1) begin
          if (!chg && kd == mdir) begin
            if (cnt == RAMP - 1) begin
              cnt = 0;
              if (spd < SMAX) spd = spd + 1;
            end else cnt = cnt + 1;
          end else cnt = 0;
        end
        mv = (mode == 1);
      end
    end else if (sp) begin
      mode = resume_mode;
      mv = (mode == 1);
    end
    evx = 0; evy = 0;
    if (mv) begin
      if (mdir == 4) evx = spd;
      if (mdir == 3) evx = -spd;
      if (mdir == 2) evy = spd;
      if (mdir == 1) evy = -spd;
    end
    ebounce = 0;
    cx = px + evx;
    cy = py + evy;
    if (cx > XHI) begin px = XHI; ebounce = 1; end
    else if (cx < XLO) begin px = XLO; ebounce = 1; end
    else px = cx;
    if (cy > YHI) begin py = YHI; ebounce = 1; end
    else if (cy < YLO) begin py = YLO; ebounce = 1; end
    else py = cy;
    if (ebounce != 0) mdir = flip(mdir);
    keyq = k;
  endtask

  task automatic compare_all();
    check("SpriteX", int'(SpriteX), px);
    check("SpriteY", int'(SpriteY), py);
    check("VelX", int'($signed(VelX)), evx);
    check("VelY", int'($signed(VelY)), evy);
    check("Moving", int'(Moving), int'(mode == 1));
    check("Paused", int'(Paused), int'(mode == 2));
    check("Bounce", int'(Bounce), ebounce);
  endtask

  task automatic frame(input int k);
    keycode = 8'(k);
    @(posedge frame_clk);
    #1;
    model_step(k);
    compare_all();
  endtask

  task automatic apply_reset();
    Reset = 1'b1;
    keycode = 8'h00;
    @(posedge frame_clk);
    #1;
    Reset = 1'b0;
    model_reset();
  endtask

  int key_tab[7];
  int cur;

  initial begin
    key_tab = '{8'h00, 8'h1A, 8'h04, 8'h16, 8'h07, 8'h2C, 8'h55};
    apply_reset();
    check("reset_x", int'(SpriteX), 320);
    check("reset_y", int'(SpriteY), 240);
    check("reset_size", int'(SpriteS), 4);
    check("reset_vel", int'(VelX) + int'(VelY), 0);
    check("reset_flags", int'({Moving, Paused, Bounce}), 0);

    frame(8'h07);
    check("d_edge_x", int'(SpriteX), 321);
    check("d_edge_vel", int'($signed(VelX)), 1);
    check("d_edge_moving", int'(Moving), 1);
    for (int i = 2; i <= 9; i++) begin
      frame(8'h07);
      if (i == 8) check("hold_f8_x", int'(SpriteX), 328);
      if (i == 9) check("hold_f9_x", int'(SpriteX), 330);
    end
    for (int i = 10; i <= 20; i++) frame(8'h07);
    check("speed3_vel", int'($signed(VelX)), 3);

    // asynchronous reset between edges
    #2;
    Reset = 1'b1;
    #1;
    check("async_x", int'(SpriteX), 320);
    check("async_y", int'(SpriteY), 240);
    check("async_vel", int'(VelX), 0);
    check("async_moving", int'(Moving), 0);
    @(posedge frame_clk);
    #1;
    Reset = 1'b0;
    keycode = 8'h00;
    model_reset();

    // long rightward run into the right edge, pause and resume, then up to the top
    for (int i = 0; i < 100; i++) frame(8'h07);
    frame(8'h00);
    frame(8'h2C);
    frame(8'h16);
    frame(8'h00);
    frame(8'h2C);
    frame(8'h00);
    frame(8'h00);
    for (int i = 0; i < 130; i++) frame(8'h1A);
    frame(8'h04);
    for (int i = 0; i < 140; i++) frame(8'h16);
    frame(8'h07);

    // randomized keyboard activity with occasional resets
    cur = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        apply_reset();
        cur = 0;
      end
      if ($urandom_range(0, 99) >= 80) begin
        cur = key_tab[$urandom_range(0, 6)];
        if (cur == 8'h55) cur = int'($urandom_range(0, 255));
      end
      frame(cur);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
